// File: rtl/shared_reg_arb_pkg.sv
// Shared types and helpers for the round-robin shared register arbiter.
// Hold counter width is fixed so MAX_HOLD up to 255 fits.
package shared_reg_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam int HOLD_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping.
// Purely combinational.
module rr_pick
  import shared_reg_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             any_req
);

  int idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ
// requesters, with forced release after MAX_HOLD writes under contention.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int MAX_HOLD = 8,
  localparam int IW = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [IW-1:0]          owner
);

  state_t            state, state_n;
  logic [IW-1:0]     cur, cur_n;
  logic [IW-1:0]     ptr, ptr_n;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [N_REQ-1:0]  gnt_n;
  logic [IW-1:0]     winner;
  logic [IW-1:0]     cur_inc;
  logic              any_req;
  logic              others;
  logic              we;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any_req(any_req)
  );

  assign others  = |(req & ~gnt);
  assign cur_inc = (int'(cur) == N_REQ - 1) ? '0 : cur + IW'(1);

  always_comb begin
    state_n = state;
    cur_n   = cur;
    ptr_n   = ptr;
    hold_n  = hold;
    gnt_n   = gnt;
    we      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          gnt_n   = N_REQ'(1) << winner;
          cur_n   = winner;
          hold_n  = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (req[cur]) begin
          we = 1'b1;
          if (hold == HOLD_W'(MAX_HOLD - 1)) begin
            hold_n = '0;
            // Write lands this edge; grant is dropped only if someone waits.
            if (others) begin
              gnt_n   = '0;
              ptr_n   = cur_inc;
              state_n = IDLE;
            end
          end else if (hold != '1) begin
            hold_n = hold + HOLD_W'(1);
          end
        end else begin
          gnt_n   = '0;
          ptr_n   = cur_inc;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur   <= '0;
      ptr   <= '0;
      hold  <= '0;
      gnt   <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      ptr   <= ptr_n;
      hold  <= hold_n;
      gnt   <= gnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
      owner   <= '0;
    end else begin
      q_valid <= we;
      if (we) begin
        q     <= wdata[cur*WIDTH +: WIDTH];
        owner <= cur;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: per-edge expectations from a
// behavioural model are queued by stimulus and popped by a monitor.
module tb_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [IW-1:0]  owner;

  shared_reg_arbiter #(
    .N_REQ(N),
    .WIDTH(W),
    .MAX_HOLD(MH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .q      (q),
    .q_valid(q_valid),
    .owner  (owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  gnt;
    logic          qv;
    logic [W-1:0]  q;
    logic [IW-1:0] owner;
  } exp_t;

  exp_t expq[$];
  int tests = 0;
  int fails = 0;

  int         m_cur = -1;
  int         m_ptr = 0;
  int         m_run = 0;
  int         m_owner = 0;
  logic [W-1:0] m_q = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic model_reset();
    m_cur = -1;
    m_ptr = 0;
    m_run = 0;
    m_owner = 0;
    m_q = '0;
  endtask

  // Behavioural rules: who owns the register, how many writes it has made,
  // and whether anyone else is waiting.
  task automatic model_step();
    exp_t e;
    bit wr;
    int c;
    wr = 0;
    if (m_cur < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (m_cur < 0 && req[c]) m_cur = c;
      end
      m_run = 0;
    end else if (req[m_cur]) begin
      wr = 1;
      m_q = wdata[m_cur*W +: W];
      m_owner = m_cur;
      m_run++;
      if (m_run % MH == 0 && (req & ~(N'(1) << m_cur)) != 0) begin
        m_ptr = (m_cur + 1) % N;
        m_cur = -1;
      end
    end else begin
      m_ptr = (m_cur + 1) % N;
      m_cur = -1;
    end
    e.gnt = (m_cur < 0) ? '0 : N'(1) << m_cur;
    e.qv = wr;
    e.q = m_q;
    e.owner = IW'(m_owner);
    expq.push_back(e);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N*W-1:0] d);
    req = r;
    wdata = d;
    model_step();
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] d);
    @(negedge clk);
    drive(r, d);
  endtask

  task automatic restart(input logic [N-1:0] r, input logic [N*W-1:0] d);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(r, d);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL underflow: output seen with no expectation at %0t",
                   $time);
        end else begin
          e = expq.pop_front();
          check("gnt", 32'(gnt), 32'(e.gnt));
          check("q_valid", 32'(q_valid), 32'(e.qv));
          check("q", 32'(q), 32'(e.q));
          check("owner", 32'(owner), 32'(e.owner));
        end
      end
    end
  end

  initial begin : stim
    logic [N*W-1:0] d;
    logic [N-1:0]   rr;

    req = N'($urandom);
    wdata = rnd_data();
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_q", 32'(q), 32'h0);
    check("rst_qv", 32'(q_valid), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);

    d = rnd_data();
    d[2*W +: W] = 8'hA5;
    rst_n = 1'b1;
    drive(4'b0100, d);
    repeat (2) cycle(4'b0100, d);
    cycle(4'b0000, rnd_data());
    cycle(4'b0000, rnd_data());

    restart(4'b1010, rnd_data());
    repeat (4) cycle(4'b1010, rnd_data());
    repeat (4) cycle(4'b1000, rnd_data());
    repeat (2) cycle(4'b0000, rnd_data());

    repeat (40) cycle(4'b0011, rnd_data());
    repeat (2) cycle(4'b0000, rnd_data());

    repeat (20) cycle(4'b1000, rnd_data());
    repeat (2) cycle(4'b0000, rnd_data());

    repeat (3) cycle(4'b0010, rnd_data());
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_q", 32'(q), 32'h0);
    check("mid_rst_qv", 32'(q_valid), 32'h0);
    check("mid_rst_owner", 32'(owner), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1011, rnd_data());
    repeat (5) cycle(4'b1011, rnd_data());

    rr = N'($urandom);
    for (int t = 0; t < 800; t++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0) rr[k] = ~rr[k];
      cycle(rr, rnd_data());
    end

    repeat (3) cycle(4'b0000, rnd_data());
    @(posedge clk);
    #2;
    check("drain", 32'(expq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit rising-edge D-register bank among N_REQ requesters.
- Each requester raises req and presents wdata. The granted requester's data is captured into the shared register every granted cycle.
- Downstream logic reads q, q_valid and owner.
- Sits between multiple producer blocks and a single storage/output register in the datapath.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, data width of the shared register.
- MAX_HOLD, 8, max consecutive granted cycles before forced release when others are waiting (1..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester access request, level-sensitive.
- wdata  input  N_REQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  N_REQ  registered one-hot grant; all zero when idle.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  one-cycle pulse: q updated on the preceding edge.
- owner  output  clog2(N_REQ)  index of requester that last wrote q.

Behaviour:
- Reset (rst_n low, asynchronous): gnt=0, q=0, q_valid=0, owner=0, rr pointer=0, hold_cnt=0, state=IDLE. Reset dominates at any time, including mid-grant. Outputs return to reset values immediately, with no partial write.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0 at an edge: winner = first set bit of req searching from pointer upward with wrap (pointer, pointer+1, ..., N_REQ-1, 0, ...).
  - On that edge gnt<=onehot(winner), hold_cnt<=0, state<=GRANT.
  - Latency: req sampled high at edge t gives gnt high after edge t.
  - If req==0, stay IDLE with gnt=0.
- GRANT (owner-candidate g = index of gnt bit):
  - Write: at each edge with req[g]=1, q<=wdata[g], owner<=g, q_valid<=1 (else q_valid<=0), hold_cnt<=hold_cnt+1 (saturating).
  - Voluntary release: req[g]=0 at an edge. No write; gnt<=0, pointer<=(g+1) mod N_REQ, state<=IDLE.
  - Forced release: at an edge where a write occurs and hold_cnt==MAX_HOLD-1 and (req & ~gnt)!=0. Write happens, then gnt<=0, pointer<=(g+1) mod N_REQ, state<=IDLE.
  - If no other requester is pending when hold_cnt reaches MAX_HOLD-1, hold_cnt<=0 and the grant continues.
- Handover: there is always exactly one cycle with gnt=0 between two grants. No requester ever sees gnt while another wrote on the same edge.
- q holds its value when no write occurs; q_valid is never high for two cycles without two writes.
- Simultaneous requests resolve purely by pointer order. The pointer only moves on release, giving fairness: every persistent requester is granted within N_REQ*(MAX_HOLD+1) cycles.
- N_REQ=1: arbiter degenerates to req-gated register with the same timing.
- wdata of non-granted requesters is ignored. X on non-granted wdata must not propagate to q.

Decomposition:
- Package shared_reg_arb_pkg: state enum (IDLE, GRANT), function for clog2, constant for hold counter width (8 bits).
- One sub-module: rr_pick. Combinational: inputs req, pointer; outputs winner index and any_req. Instantiated once in shared_reg_arbiter.
- Shared register and q_valid/owner registers are inline in the top module.

Test Plan:
- Reset check:
  - Stimulus: assert rst_n=0 with random inputs.
  - Required: gnt=0, q=0, q_valid=0, owner=0.
- Single requester:
  - Stimulus: release reset; req=4'b0100, wdata[2]=8'hA5 for 3 edges, then req=0.
  - Required: gnt=4'b0100 after edge 1; q=8'hA5 and q_valid=1 after edges 2 and 3; owner=2; gnt=0 after edge 4.
- Simultaneous start:
  - Stimulus: req=4'b1010 after reset, pointer=0.
  - Required: gnt=4'b0010 first; on release, one idle cycle, then gnt=4'b1000.
- Forced release:
  - Stimulus: MAX_HOLD=8, req=4'b0011 held continuously.
  - Required: requester 0 writes exactly 8 times, gnt=0 for 1 cycle, requester 1 granted; pattern alternates indefinitely.
- No contention:
  - Stimulus: only req[3] high for 20 cycles.
  - Required: gnt[3] continuous, 19 consecutive q_valid pulses with no forced release.
- Reset mid-grant:
  - Stimulus: drop rst_n asynchronously between edges while gnt[1]=1.
  - Required: gnt, q, q_valid clear immediately. After release, first grant again follows pointer=0 order.
